// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetch stage feeding the decode/register stage. Issues word requests to
//   instruction memory, buffers in-order responses (with their PCs) in a
//   DEPTH-entry FIFO and hands them on over a valid/ready interface. A branch
//   redirect flushes the FIFO and drops every response still in flight; a
//   response equal to END_WORD halts further fetching.
//
//   Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
//   arrives while the FIFO is empty and nothing is being dropped is presented
//   to the consumer in the same cycle, and skips the FIFO if it is taken.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-low reset
//   imem_req, imem_addr     fetch request (accepted the cycle it is asserted)
//   imem_rvalid, imem_rdata in-order fetch response, latency >= 1
//   redirect, redirect_pc   taken branch/jump; low two PC bits are ignored
//   inst_valid, inst_ready  head-of-queue handshake towards the datapath
//   inst_data, inst_pc      head instruction and its PC
//   occupancy               number of buffered entries
//   end_of_program          sticky, set once the END_WORD entry is consumed
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_WORD = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       end_of_program
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [CntW:0] sumT;
  localparam sumT DepthLim = sumT'(DEPTH);

  logic [31:0]     dataMem [DEPTH];
  logic [31:0]     pcMem   [DEPTH];
  logic [PtrW-1:0] headPtr, tailPtr;
  logic [CntW-1:0] count, outstanding, dropCnt;
  logic [31:0]     fetchPc, respPc, holdData, holdPc, redirTarget;
  logic            stopFlag, eopFlag;

  sumT  inUse;
  logic issue, respValid, respKeep, headValid, headIsEnd;
  logic bypassView, bypassTake, pushEn, popEn;

  always_comb begin
    redirTarget = redirect_pc & ~32'h3;
    inUse       = {1'b0, count} + {1'b0, outstanding};
    // Credit rule: buffered + in-flight never exceeds DEPTH, so a response
    // always finds a free slot.
    issue       = reset & ~stopFlag & ~redirect & (inUse < DepthLim);
    respValid   = imem_rvalid & (outstanding != '0);
    respKeep    = respValid & (dropCnt == '0) & ~redirect;
    headValid   = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypassView  = reset & respValid & ~headValid & (dropCnt == '0);
`else
    bypassView  = 1'b0;
`endif
    bypassTake  = bypassView & inst_ready & ~redirect;
    popEn       = headValid & inst_ready & ~redirect;
    pushEn      = respKeep & ~bypassTake;
    headIsEnd   = (dataMem[headPtr] == END_WORD);
    inst_valid  = reset & (headValid | bypassView);
    if (headValid) begin
      inst_data = dataMem[headPtr];
      inst_pc   = pcMem[headPtr];
    end else if (bypassView) begin
      inst_data = imem_rdata;
      inst_pc   = respPc;
    end else begin
      // Holding registers keep the last presented head visible after the
      // FIFO drains or is flushed.
      inst_data = holdData;
      inst_pc   = holdPc;
    end
  end

  assign imem_req       = issue;
  assign imem_addr      = fetchPc;
  assign occupancy      = count;
  assign end_of_program = eopFlag;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      stopFlag    <= 1'b0;
      eopFlag     <= 1'b0;
      holdData    <= '0;
      holdPc      <= '0;
    end else begin
      outstanding <= outstanding + CntW'(issue) - CntW'(respValid);
      if (inst_valid) begin
        holdData <= inst_data;
        holdPc   <= inst_pc;
      end
      if (redirect) begin
        // Everything still in flight (less any response landing now) must be
        // discarded; stacking redirects just re-snapshots the in-flight count.
        fetchPc  <= redirTarget;
        respPc   <= redirTarget;
        headPtr  <= '0;
        tailPtr  <= '0;
        count    <= '0;
        dropCnt  <= outstanding - CntW'(respValid);
        stopFlag <= 1'b0;
        eopFlag  <= 1'b0;
      end else begin
        if (issue) fetchPc <= fetchPc + 32'd4;
        if (respValid) begin
          if (dropCnt != '0) begin
            dropCnt <= dropCnt - CntW'(1);
          end else begin
            respPc <= respPc + 32'd4;
            if (imem_rdata == END_WORD) stopFlag <= 1'b1;
          end
        end
        if (pushEn) tailPtr <= tailPtr + PtrW'(1);
        if (popEn)  headPtr <= headPtr + PtrW'(1);
        count <= count + CntW'(pushEn) - CntW'(popEn);
        if ((popEn & headIsEnd) | (bypassTake & (imem_rdata == END_WORD)))
          eopFlag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && pushEn) begin
      dataMem[tailPtr] <= imem_rdata;
      pcMem[tailPtr]   <= respPc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue
//   Scoreboard bench for inst_fetch_queue. The reference is the program itself:
//   after every reset/redirect the expected delivery stream is the sequence of
//   words starting at the target PC, and the expected fetch addresses advance
//   by 4 from the same PC. A memory model answers requests in order with a
//   programmable latency and knows which responses are stale after a redirect.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] END_WORD = 32'h0000_0000;

  logic        clock, reset;
  logic        imem_req, imem_rvalid, redirect, inst_valid, inst_ready, end_of_program;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .END_WORD(END_WORD)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .occupancy(occupancy), .end_of_program(end_of_program)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          nCmp = 0;
  int          nErr = 0;
  int unsigned cyc  = 0;
  logic [31:0] endAddr = 32'h0000_0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == endAddr) return END_WORD;
    return ((a ^ 32'hA5A5_0000) * 32'h9E37_79B1) | 32'h3;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] data; } expT;
  expT expQ[$];

  task automatic startStream(input logic [31:0] p);
    logic [31:0] a;
    a = p;
    expQ.delete();
    for (int unsigned i = 0; i < 512; i++) begin
      expQ.push_back('{a, memWord(a)});
      a += 32'd4;
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } reqT;
  reqT         pend[$];
  int          lat = 1;
  int unsigned lastDue, endCycle, reqCount = 0;
  bit          curValid, curStale, endSeen;
  logic [31:0] expFetch, maxAddr, lastReqAddr;

  initial begin : memModel
    reqT r;
    int unsigned due;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    curValid = 0; curStale = 0; endSeen = 0; lastDue = 0;
    expFetch = RESET_PC; maxAddr = '0; lastReqAddr = '0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        pend.delete();
        curValid = 0; endSeen = 0; lastDue = cyc;
        expFetch = RESET_PC; maxAddr = '0;
      end else begin
        if (redirect) begin
          foreach (pend[i]) pend[i].stale = 1;
          curStale = 1;
        end
        if (curValid && !curStale && imem_rdata == END_WORD && !endSeen) begin
          endSeen = 1; endCycle = cyc;
        end
        if (endSeen && cyc > endCycle) check("noReqAfterEnd", imem_req, 0);
        if (imem_req) begin
          check("reqAddr", imem_addr, expFetch);
          reqCount++;
          lastReqAddr = imem_addr;
          if (imem_addr > maxAddr) maxAddr = imem_addr;
          due = cyc + lat;
          if (due <= lastDue) due = lastDue + 1;
          lastDue = due;
          pend.push_back('{imem_addr, due, 0});
          expFetch += 32'd4;
        end
        if (redirect) begin
          expFetch = redirect_pc & ~32'h3;
          endSeen  = 0;
        end
      end
      @(posedge clock);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(r.addr);
        curValid = 1; curStale = r.stale;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        curValid = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit expEop    = 0;
  int delivered = 0;

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        expEop = 0;
      end else begin
        check("endOfProgram", end_of_program, expEop);
        if (inst_valid && inst_ready && !redirect) begin
          delivered++;
          if (expQ.size() == 0) begin
            nCmp++; nErr++;
            $display("FAIL streamOverrun: got pc %h expected no instruction", inst_pc);
          end else begin
            e = expQ.pop_front();
            check("instPc", inst_pc, e.pc);
            check("instData", inst_data, e.data);
            if (e.data == END_WORD) expEop = 1;
          end
        end
        if (redirect) expEop = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyReset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycles(1);
      @(negedge clock);
      check("rstReq", imem_req, 0);
      check("rstValid", inst_valid, 0);
      check("rstData", inst_data, 0);
      check("rstPc", inst_pc, 0);
      check("rstOcc", occupancy, 0);
      check("rstEop", end_of_program, 0);
    end
    cycles(1);
    startStream(RESET_PC);
    reset = 1'b1;
  endtask

  task automatic doRedirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    startStream(target & ~32'h3);
    cycles(1);
    redirect = 1'b0;
  endtask

  task automatic waitReq(output int unsigned at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (imem_req) begin ok = 1; at = cyc; end
    end
  endtask

  initial begin : stim
    int unsigned reqCyc, validCyc, r0;
    bit ok, gotValid;
    logic [31:0] base;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    #1;

    // reset, latency 1, streaming fetch from RESET_PC
    lat = 1;
    applyReset(3);
    waitReq(reqCyc, ok);
    check("firstReqSeen", {31'b0, ok}, 1);
    check("firstReqAddr", imem_addr, RESET_PC);
    gotValid = 0; validCyc = 0;
    for (int i = 0; i < 10 && !gotValid; i++) begin
      if (i > 0) @(negedge clock);
      if (inst_valid) begin gotValid = 1; validCyc = cyc; end
    end
    check("firstValidSeen", {31'b0, gotValid}, 1);
`ifdef FETCH_BYPASS_EN
    check("firstLatency", validCyc - reqCyc, 1);
    check("bypassOcc", occupancy, 0);
`else
    check("firstLatency", validCyc - reqCyc, 2);
`endif
    check("firstInstPc", inst_pc, RESET_PC);
    cycles(20);

    // back-pressure: credit limit, then a single pop frees one request
    inst_ready = 1'b0;
    applyReset(1);
    r0 = reqCount;
    cycles(20);
    @(negedge clock);
    check("stallReqCount", reqCount - r0, 4);
    check("stallOcc", occupancy, 4);
    check("stallReq", imem_req, 0);
    cycles(1);
    inst_ready = 1'b1;
    cycles(1);
    inst_ready = 1'b0;
    cycles(10);
    @(negedge clock);
    check("refillReqCount", reqCount - r0, 5);
    check("refillAddr", lastReqAddr, 32'h10);
    check("refillOcc", occupancy, 4);
    cycles(1);

    // redirect with latency 3 and several responses in flight
    inst_ready = 1'b1;
    applyReset(1);
    lat = 3;
    cycles(15);
    doRedirect(32'h0000_0103);
    @(negedge clock);
    check("flushOcc", occupancy, 0);
    check("flushValid", inst_valid, 0);
    gotValid = 0;
    for (int i = 0; i < 30 && !gotValid; i++) begin
      @(negedge clock);
      if (inst_valid) gotValid = 1;
    end
    check("redirValidSeen", {31'b0, gotValid}, 1);
    check("redirFirstPc", inst_pc, 32'h100);
    cycles(10);

    // end of program at 0x14, then redirect clears and resumes
    lat = 1;
    endAddr = 32'h14;
    applyReset(1);
    gotValid = 0;
    for (int i = 0; i < 40 && !gotValid; i++) begin
      @(negedge clock);
      if (end_of_program) gotValid = 1;
    end
    check("eopSeen", end_of_program, 1);
    cycles(5);
    check("lastFetchBeforeHalt", maxAddr, 32'h18);
    r0 = reqCount;
    doRedirect(32'h40);
    @(negedge clock);
    check("eopCleared", end_of_program, 0);
    cycles(10);
    check("resumed", {31'b0, reqCount > r0}, 1);

    // reset with responses both buffered and in flight
    lat = 2;
    inst_ready = 1'b0;
    applyReset(1);
    cycles(4);
    applyReset(1);
    inst_ready = 1'b1;
    waitReq(reqCyc, ok);
    check("postResetReqSeen", {31'b0, ok}, 1);
    check("postResetAddr", imem_addr, RESET_PC);
    cycles(10);

    // randomized traffic with redirects, halts, wrap-around and latency changes
    endAddr = 32'h200;
    applyReset(1);
    delivered = 0;
    for (int i = 0; i < 2500; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 9) == 0) base = 32'hFFFF_FFE0 | ($urandom_range(0, 7) << 2);
        else base = $urandom_range(0, 255) << 2;
        redirect    = 1'b1;
        redirect_pc = base | $urandom_range(0, 3);
        startStream(base);
      end else begin
        redirect = 1'b0;
      end
      cycles(1);
    end
    redirect   = 1'b0;
    inst_ready = 1'b1;
    cycles(20);
    check("randomProgress", {31'b0, delivered > 200}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr + 1);
    $fatal(1);
  end

endmodule
